decoder: RTL and testbench



---
 rtl/decoder.sv | 126 ++++++++++++
 tb/tb_decoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/decoder.sv
// HSI line receiver: recovers 11-bit frames (start, 8 data, odd parity, stop)
// from an oversampled serial line and presents the byte with error flags.
module decoder #(
    parameter int OVS       = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       d,
    output logic [7:0] q,
    output logic       q_rdy,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(OVS);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_s1, r_s2;
    logic            r_prev;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_bitcnt;
    logic [7:0]      r_sh;
    logic            r_par;
    logic [7:0]      r_q;
    logic            r_q_rdy, r_perr, r_ferr, r_busy;

    logic            w_ds, w_mid, w_last;
    logic            w_cnt_clr, w_shift, w_par_ld, w_done, w_busy_set;

    assign w_ds   = r_s2;
    assign w_mid  = (r_cnt == CW'(OVS/2 - 1));
    assign w_last = (r_cnt == CW'(OVS - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_shift     = 1'b0;
        w_par_ld    = 1'b0;
        w_done      = 1'b0;
        w_busy_set  = 1'b0;
        if (clk_en) begin
            case (r_state)
                S_IDLE: if (r_prev && !w_ds) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_START;
                end
                // Mid-bit recheck rejects short low glitches.
                S_START: if (w_mid) begin
                    if (!w_ds) begin
                        w_state_nxt = S_DATA;
                        w_busy_set  = 1'b1;
                        w_cnt_clr   = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_DATA: if (w_last) begin
                    w_shift = 1'b1;
                    if (r_bitcnt == 4'd7) w_state_nxt = S_PARITY;
                end
                S_PARITY: if (w_last) begin
                    w_par_ld    = 1'b1;
                    w_state_nxt = S_STOP;
                end
                S_STOP: if (w_last) begin
                    w_done      = 1'b1;
                    w_state_nxt = w_ds ? S_IDLE : S_BREAK;
                end
                S_BREAK: if (w_ds) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_s1     <= 1'b1;
            r_s2     <= 1'b1;
            r_prev   <= 1'b0;
            r_cnt    <= '0;
            r_bitcnt <= 4'd0;
            r_sh     <= 8'h00;
            r_par    <= 1'b0;
            r_q      <= 8'h00;
            r_q_rdy  <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_s1    <= d;
            r_s2    <= r_s1;
            r_q_rdy <= 1'b0;
            r_state <= w_state_nxt;
            if (clk_en) begin
                r_prev <= w_ds;
                r_cnt  <= w_cnt_clr ? '0 : r_cnt + CW'(1);
            end
            if (w_shift) begin
                r_sh     <= LSB_FIRST ? {w_ds, r_sh[7:1]} : {r_sh[6:0], w_ds};
                r_bitcnt <= (r_bitcnt == 4'd7) ? 4'd0 : r_bitcnt + 4'd1;
            end
            if (w_par_ld)   r_par  <= w_ds;
            if (w_busy_set) r_busy <= 1'b1;
            if (w_done) begin
                r_q     <= r_sh;
                r_perr  <= ~(^{r_sh, r_par});
                r_ferr  <= ~w_ds;
                r_q_rdy <= 1'b1;
                r_busy  <= 1'b0;
            end
        end
    end

    assign q          = r_q;
    assign q_rdy      = r_q_rdy;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign busy       = r_busy;
endmodule

// File: tb/tb_decoder.sv
// Bench for decoder: table-driven frames, hand-written corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_decoder;
    localparam int OVS = 8;
    localparam int TPB = 4;

    logic       clk = 1'b0, rst = 1'b1, clk_en = 1'b0, d = 1'b1;
    logic [7:0] q;
    logic       q_rdy, parity_err, frame_err, busy;

    decoder #(.OVS(OVS), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .d(d), .q(q), .q_rdy(q_rdy),
        .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int en_cnt = 0;
    always @(posedge clk) begin
        #1;
        en_cnt = (en_cnt + 1) % TPB;
        clk_en = (en_cnt == 0);
    end

    typedef struct { logic [7:0] q; logic pe; logic fe; longint t; } cap_t;
    cap_t   caps[$];
    cap_t   exps[$];
    longint cyc = 0;
    int     busy_cyc = 0;
    int     dbl = 0;
    logic   rdy_d = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (q_rdy) caps.push_back('{q, parity_err, frame_err, cyc});
        if (q_rdy && rdy_d) dbl++;
        rdy_d = q_rdy;
        if (busy) busy_cyc++;
    end

    int nchk = 0, nerr = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!clk_en) @(posedge clk);
        end
        #2;
    endtask

    task automatic send_bit(input bit b);
        d = b;
        ticks(OVS);
    endtask

    task automatic send_frame(input logic [7:0] data, input bit p, input bit s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(p);
        send_bit(s);
    endtask

    task automatic idle(input int nb);
        d = 1'b1;
        ticks(nb * OVS);
    endtask

    // Reference: the delivered result of a frame depends only on its fields.
    task automatic model(input logic [7:0] data, input bit p, input bit s);
        cap_t e;
        e.q  = data;
        e.pe = ((($countones(data) + int'(p)) % 2) == 0);
        e.fe = !s;
        e.t  = 0;
        exps.push_back(e);
    endtask

    task automatic cmp_all(input string tag);
        int n;
        chk({tag, "_count"}, caps.size(), exps.size());
        n = (caps.size() < exps.size()) ? caps.size() : exps.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_q"},  caps[i].q,  exps[i].q);
            chk({tag, "_pe"}, caps[i].pe, exps[i].pe);
            chk({tag, "_fe"}, caps[i].fe, exps[i].fe);
        end
        caps.delete();
        exps.delete();
    endtask

    typedef struct { logic [7:0] data; bit p; bit s; logic [7:0] eq; bit epe; bit efe; } vec_t;
    vec_t tbl[5];

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
        tbl[2] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
        tbl[3] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0};
        tbl[4] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};

        rst = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("rst_q", q, 8'h00);
        chk("rst_q_rdy", q_rdy, 0);
        chk("rst_pe", parity_err, 0);
        chk("rst_fe", frame_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        idle(2);
        caps.delete();

        // Table frames; entry 1 leaves parity_err set, entry 2 must clear it.
        for (int i = 0; i < 5; i++) begin
            busy_cyc = 0;
            caps.delete();
            send_frame(tbl[i].data, tbl[i].p, tbl[i].s);
            idle(2);
            chk("tbl_count", caps.size(), 1);
            if (caps.size() > 0) begin
                chk("tbl_q", caps[0].q, tbl[i].eq);
                chk("tbl_pe", caps[0].pe, tbl[i].epe);
                chk("tbl_fe", caps[0].fe, tbl[i].efe);
            end
            if (i == 0) chk("busy_len", busy_cyc, 10 * OVS * TPB);
        end
        caps.delete();

        // Break: stop bit low, line held low for 20 bit periods.
        send_frame(8'h00, 1'b1, 1'b0);
        d = 1'b0;
        ticks(20 * OVS);
        chk("brk_count", caps.size(), 1);
        if (caps.size() > 0) chk("brk_fe", caps[0].fe, 1);
        caps.delete();
        idle(2);
        send_frame(8'h55, 1'b1, 1'b1); model(8'h55, 1'b1, 1'b1);
        idle(2);
        cmp_all("brk_rec");

        // Start glitch of two samples.
        busy_cyc = 0;
        d = 1'b0;
        ticks(2);
        d = 1'b1;
        ticks(3 * OVS);
        chk("glitch_busy", busy_cyc, 0);
        chk("glitch_rdy", caps.size(), 0);
        caps.delete();

        // Back-to-back frames, no idle between them.
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        idle(2);
        if (caps.size() == 2) chk("b2b_gap", caps[1].t - caps[0].t, 11 * OVS * TPB);
        else chk("b2b_gap_count", caps.size(), 2);
        model(8'h00, 1'b1, 1'b1);
        model(8'hFF, 1'b1, 1'b1);
        cmp_all("b2b");

        // Reset after four data bits of 8'hF0.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rst = 1'b1;
        @(posedge clk); @(posedge clk);
        #2;
        chk("mrst_q", q, 8'h00);
        chk("mrst_q_rdy", q_rdy, 0);
        chk("mrst_pe", parity_err, 0);
        chk("mrst_fe", frame_err, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_norx", caps.size(), 0);
        rst = 1'b0;
        idle(2);
        send_frame(8'h3C, 1'b1, 1'b1); model(8'h3C, 1'b1, 1'b1);
        idle(2);
        cmp_all("mrst_rec");

        // Randomized frames with random parity/stop errors and gaps.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] data;
            bit p, s;
            data = 8'($urandom);
            p    = 1'($urandom);
            s    = ($urandom_range(0, 3) != 0);
            send_frame(data, p, s);
            model(data, p, s);
            if (!s) begin
                d = 1'b0;
                ticks(int'($urandom_range(0, 3)) * OVS + 1);
                idle(1);
            end else begin
                idle(int'($urandom_range(0, 2)));
            end
        end
        idle(2);
        cmp_all("rand");

        chk("q_rdy_width", dbl, 0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
